// File: rtl/complex_nr_pkg.sv
// complex_nr_pkg: shared encodings, fixed operands and LFSR step for the operand driver.
// Revision 1.0
`default_nettype none

package complex_nr_pkg;

  typedef enum logic [1:0] {
    MODE_FIXED    = 2'd0,
    MODE_LFSR_ONE = 2'd1,
    MODE_CORNER   = 2'd2,
    MODE_LFSR_N   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_VALID = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int unsigned FIX_OP1_RE = 2;
  localparam int unsigned FIX_OP1_IM = 3;
  localparam int unsigned FIX_OP2_RE = 4;
  localparam int unsigned FIX_OP2_IM = 2;

  // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/complex_nr_lfsr.sv
// complex_nr_lfsr: 32-bit Galois LFSR with seed reload and advance enable.
// Revision 1.0
`default_nettype none

module complex_nr_lfsr
  import complex_nr_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (adv) begin
      state <= lfsr_next(state);
    end
  end

endmodule

`default_nettype wire

// File: rtl/complex_nr_op_driver.sv
// complex_nr_op_driver: issues complex operand words to a multiplier over a valid/ready handshake.
// Revision 1.0
`default_nettype none

module complex_nr_op_driver
  import complex_nr_pkg::*;
#(
  parameter int          DATA_WIDTH     = 8,
  parameter int          TRANSACTION_NR = 20,
  parameter int          GAP_CYCLES     = 2,
  parameter logic [31:0] LFSR_SEED      = 32'h1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sw_rst,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic                    op_ready,
  output logic                    op_val,
  output logic [4*DATA_WIDTH-1:0] op_data,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             trans_cnt
);

  localparam int OPW = 4 * DATA_WIDTH;
  localparam logic [OPW-1:0] FIXED_WORD = {DATA_WIDTH'(FIX_OP1_RE), DATA_WIDTH'(FIX_OP1_IM),
                                           DATA_WIDTH'(FIX_OP2_RE), DATA_WIDTH'(FIX_OP2_IM)};
  localparam logic [9:0]  GAP_LAST     = (GAP_CYCLES > 0) ? 10'(GAP_CYCLES - 1) : 10'd0;
  localparam logic [15:0] RUN_TARGET_N = 16'(TRANSACTION_NR);

  state_e          state;
  state_e          state_nxt;
  mode_e           run_mode;
  logic [9:0]      gap_cnt;
  logic [31:0]     lfsr_state;
  logic [31:0]     lfsr_adv;
  logic [OPW-1:0]  word_nxt;
  logic [15:0]     cnt_inc;
  logic [15:0]     run_target;
  logic            lfsr_en;
  logic            xfer;

  assign lfsr_en    = (state == ST_LOAD) &&
                      ((run_mode == MODE_LFSR_ONE) || (run_mode == MODE_LFSR_N));
  assign lfsr_adv   = lfsr_next(lfsr_state);
  assign xfer       = (state == ST_VALID) && op_val && op_ready;
  assign cnt_inc    = trans_cnt + 16'd1;
  assign run_target = (run_mode == MODE_LFSR_N) ? RUN_TARGET_N : 16'd1;

  complex_nr_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rstn  (rstn),
    .load  (sw_rst),
    .adv   (lfsr_en),
    .state (lfsr_state)
  );

  // The word loaded in LOAD uses the post-advance LFSR value, matching the register update.
  always_comb begin
    word_nxt = lfsr_adv[OPW-1:0];
    case (run_mode)
      MODE_FIXED:  word_nxt = FIXED_WORD;
      MODE_CORNER: word_nxt = '1;
      default:     word_nxt = lfsr_adv[OPW-1:0];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else if (sw_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_VALID;
      ST_VALID: begin
        if (xfer) begin
          if (cnt_inc == run_target) state_nxt = ST_DONE;
          else if (GAP_CYCLES == 0)  state_nxt = ST_LOAD;
          else                       state_nxt = ST_GAP;
        end
      end
      ST_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ST_LOAD;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_mode  <= MODE_FIXED;
      op_val    <= 1'b0;
      op_data   <= '0;
      trans_cnt <= 16'd0;
      gap_cnt   <= 10'd0;
    end else if (sw_rst) begin
      run_mode  <= MODE_FIXED;
      op_val    <= 1'b0;
      op_data   <= '0;
      trans_cnt <= 16'd0;
      gap_cnt   <= 10'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            run_mode  <= mode_e'(mode);
            trans_cnt <= 16'd0;
          end
        end
        ST_LOAD: begin
          op_val  <= 1'b1;
          op_data <= word_nxt;
        end
        ST_VALID: begin
          if (xfer) begin
            op_val    <= 1'b0;
            trans_cnt <= cnt_inc;
            gap_cnt   <= 10'd0;
          end
        end
        ST_GAP:  gap_cnt <= gap_cnt + 10'd1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
